// File: rtl/serial_six_bit_adder_pkg.sv
// Shared constants and state encoding for the bit-serial adder.
package serial_six_bit_adder_pkg;

  // Default operand/result width.
  localparam int WIDTH_DEFAULT = 6;

  // Controller state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_six_bit_adder_full_adder.sv
// Single-bit full adder built from gate primitives; the one arithmetic cell
// that the serial adder reuses for every bit position.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic ab_x;
  logic ab_a;
  logic cx_a;

  xor g_x0 (ab_x, a, b);
  xor g_x1 (s, ab_x, cin);
  and g_a0 (ab_a, a, b);
  and g_a1 (cx_a, ab_x, cin);
  or  g_o0 (cout, ab_a, cx_a);

endmodule

// File: rtl/serial_six_bit_adder.sv
// Bit-serial adder: captures two operands on start, adds one bit per clock
// LSB first through a single full adder with a registered carry, then presents
// sum/carry alongside a one-cycle done strobe.
module serial_six_bit_adder
  import serial_six_bit_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cy_q, cy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] acc_shift;

  // The serial bit slice: always looks at the current LSBs and carry.
  full_adder u_fa (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .cin  (cy_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at bit 0.
  assign acc_shift = {fa_s, acc_q[WIDTH-1:1]};

  // Next-state, datapath and result-capture logic.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          acc_d   = '0;
          cy_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d = acc_shift;
        cy_d  = fa_co;
        opa_d = opa_q >> 1;
        opb_d = opb_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Final bit: publish the complete result; sum never shows partials.
          sum_d   = acc_shift;
          carry_d = fa_co;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign sum   = sum_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_serial_six_bit_adder.sv
// Scoreboard bench for the bit-serial adder: stimulus pushes expected
// {carry,sum} on each accepted start; a monitor pops on every done strobe.
module tb_serial_six_bit_adder;

  logic       clk;
  logic       reset;
  logic       start;
  logic [5:0] a;
  logic [5:0] b;
  logic       busy;
  logic       done;
  logic [5:0] sum;
  logic       carry;

  int checks;
  int failures;
  int done_pulses;
  int cyc;

  logic [6:0] exp_q[$];

  serial_six_bit_adder dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Ripple-borrow subtractor model used for the round-trip check.
  function automatic logic [5:0] ripple_sub(input logic [5:0] x, input logic [5:0] y);
    logic [5:0] d;
    logic       bw;
    bw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d[i] = x[i] ^ y[i] ^ bw;
      bw   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & bw);
    end
    return d;
  endfunction

  // Monitor: every done strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      done_pulses++;
      $display("txn sum=%b carry=%b", sum, carry);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual sum=%b carry=%b required no pulse", sum, carry);
      end else begin
        check("scoreboard", {25'd0, carry, sum}, {25'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic run_op(input logic [5:0] x, input logic [5:0] y,
                        input logic [6:0] exp, output int busy_cycles);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 20) begin
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int   bc;
    int   c1;
    int   c2;
    int   dp0;
    bit   ok;
    logic [5:0] x;
    logic [5:0] y;
    logic [6:0] full;

    checks = 0; failures = 0; done_pulses = 0; cyc = 0;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_sum", {26'd0, sum}, 32'd0);
    check("reset_carry", {31'd0, carry}, 32'd0);

    // Overflow: 63 + 1 = 64 -> sum 0, carry 1.
    run_op(6'b111111, 6'b000001, 7'b1_000000, bc);
    check("ovf_busy_cycles", bc, 6);
    check("ovf_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("ovf_done_falls", {31'd0, done}, 32'd0);
    check("ovf_sum_held", {25'd0, carry, sum}, {25'd0, 7'b1_000000});

    // Start pulsed mid-RUN must be ignored: 32 + 32 = 64.
    dp0 = done_pulses;
    @(negedge clk);
    a = 6'b100000; b = 6'b100000; start = 1'b1;
    exp_q.push_back(7'b1_000000);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 6'b000001; b = 6'b000001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(ok);
    check("ign_timeout", {31'd0, ok}, 32'd1);
    repeat (10) @(negedge clk);
    check("ign_one_pulse", done_pulses - dp0, 1);

    // Basic add: 10 + 4 = 14.
    run_op(6'b001010, 6'b000100, 7'b0_001110, bc);
    check("basic_busy_cycles", bc, 6);
    check("basic_done", {31'd0, done}, 32'd1);
    @(negedge clk);

    // Reset on the third RUN cycle aborts the operation.
    dp0 = done_pulses;
    @(negedge clk);
    a = 6'b010000; b = 6'b000001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {26'd0, sum}, 32'd0);
    check("rst_carry", {31'd0, carry}, 32'd0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_no_done", done_pulses - dp0, 0);

    // Back-to-back: 5 + 3 = 8, then 2 + 2 = 4 with start held through DONE.
    @(negedge clk);
    a = 6'b000101; b = 6'b000011; start = 1'b1;
    exp_q.push_back(7'b0_001000);
    wait_done(ok);
    check("b2b_first_timeout", {31'd0, ok}, 32'd1);
    c1 = cyc;
    a = 6'b000010; b = 6'b000010;
    exp_q.push_back(7'b0_000100);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy_again", {31'd0, busy}, 32'd1);
    wait_done(ok);
    check("b2b_second_timeout", {31'd0, ok}, 32'd1);
    c2 = cyc;
    check("b2b_spacing", c2 - c1, 7);
    @(negedge clk);

    // Round trip over single-bit operands.
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        x = 6'd1 << i;
        y = 6'd1 << j;
        full = {1'b0, x} + {1'b0, y};
        run_op(x, y, full, bc);
        check("rt_done", {31'd0, done}, 32'd1);
        check("rt_sum", {26'd0, sum}, {26'd0, full[5:0]});
        if (carry == 1'b0)
          check("rt_sub", {26'd0, ripple_sub(sum, y)}, {26'd0, x});
      end
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
